id_operand_stage: RTL and testbench

Decode-side operand stage between instruction decode and EX in the pipelined RV32I core. It drives read addresses into the 32×32 register file and bypasses same-cycle write-back data, because the register file writes on the clock edge and its asynchronous read does not yet show the new value. It detects load-use hazards, emits the stall, and owns the ID/EX pipeline register, including bubble insertion and flush. It also keeps two saturating performance counters.

---
 rtl/id_operand_stage_if.sv | 65 ++++++
 rtl/id_operand_stage.sv | 128 ++++++++++++
 tb/tb_id_operand_stage.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_operand_stage_if.sv
// ID-to-EX operand stage bus: decode-side inputs, register-file read port,
// write-back bypass, flush/stall handshake, ID/EX register outputs and
// performance counters.
interface id_operand_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  // decode side
  logic            id_valid;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic [4:0]      id_rd;
  logic            id_reg_write;
  logic            id_mem_read;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_imm;
  // register file read port
  logic [4:0]      rf_rs1_addr;
  logic [4:0]      rf_rs2_addr;
  logic [XLEN-1:0] rf_rs1_dout;
  logic [XLEN-1:0] rf_rs2_dout;
  // write-back
  logic            wb_reg_write;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_din;
  // pipeline control
  logic            flush;
  logic            stall;
  // ID/EX register
  logic            ex_valid;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_rs1_val;
  logic [XLEN-1:0] ex_rs2_val;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  // counters
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  // the operand stage itself
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_mem_read, id_pc, id_imm,
           rf_rs1_dout, rf_rs2_dout, wb_reg_write, wb_rd, wb_din, flush,
    output rf_rs1_addr, rf_rs2_addr, stall,
           ex_valid, ex_reg_write, ex_mem_read, ex_rs1, ex_rs2, ex_rd,
           ex_rs1_val, ex_rs2_val, ex_pc, ex_imm, stall_count, flush_count
  );

  // the surrounding pipeline (decode, register file, write-back, EX)
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_mem_read, id_pc, id_imm,
           rf_rs1_dout, rf_rs2_dout, wb_reg_write, wb_rd, wb_din, flush,
    input  rf_rs1_addr, rf_rs2_addr, stall,
           ex_valid, ex_reg_write, ex_mem_read, ex_rs1, ex_rs2, ex_rd,
           ex_rs1_val, ex_rs2_val, ex_pc, ex_imm, stall_count, flush_count
  );
endinterface

// File: rtl/id_operand_stage.sv
// Decode-side operand stage: register-file addressing with same-cycle
// write-back bypass, load-use hazard stall, ID/EX pipeline register with
// bubble/flush, and saturating stall/flush event counters.
module id_operand_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  id_operand_stage_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // source-operand views indexed 0 = rs1, 1 = rs2
  logic [1:0][4:0]      src_idx;
  logic [1:0]           src_use;
  logic [1:0][XLEN-1:0] src_rf;
  logic [1:0][XLEN-1:0] src_val;
  logic [1:0]           src_hit;

  // ID/EX state
  logic            ex_valid_reg;
  logic            ex_reg_write_reg;
  logic            ex_mem_read_reg;
  logic [4:0]      ex_rs1_reg;
  logic [4:0]      ex_rs2_reg;
  logic [4:0]      ex_rd_reg;
  logic [XLEN-1:0] ex_rs1_val_reg;
  logic [XLEN-1:0] ex_rs2_val_reg;
  logic [XLEN-1:0] ex_pc_reg;
  logic [XLEN-1:0] ex_imm_reg;
  logic [CNT_W-1:0] stall_count_reg;
  logic [CNT_W-1:0] flush_count_reg;

  logic load_in_ex;
  logic hz;
  logic stall;
  logic kill;

  assign src_idx[0] = bus.id_rs1;
  assign src_idx[1] = bus.id_rs2;
  assign src_use[0] = bus.id_use_rs1;
  assign src_use[1] = bus.id_use_rs2;
  assign src_rf[0]  = bus.rf_rs1_dout;
  assign src_rf[1]  = bus.rf_rs2_dout;

  // x0 reads as zero; otherwise the write landing this edge wins over the
  // stale asynchronous register-file read. Because idx != 0 is checked first,
  // a write-back to x0 can never bypass.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_val[gi] = (src_idx[gi] == 5'd0) ? '0 :
                           (bus.wb_reg_write && (bus.wb_rd == src_idx[gi])) ? bus.wb_din :
                           src_rf[gi];
      assign src_hit[gi] = src_use[gi] && (src_idx[gi] == ex_rd_reg);
    end
  endgenerate

  // a load currently in EX whose result is not ready for a dependent in ID
  assign load_in_ex = ex_valid_reg && ex_mem_read_reg && (ex_rd_reg != 5'd0);
  assign hz         = load_in_ex && bus.id_valid && (|src_hit);
  // flush discards the ID instruction, so there is nothing to hold
  assign stall      = hz && !bus.flush;
  assign kill       = bus.flush || hz;

  assign bus.rf_rs1_addr = bus.id_rs1;
  assign bus.rf_rs2_addr = bus.id_rs2;
  assign bus.stall       = stall;

  // ID/EX register: reset clears everything, flush or hazard inserts a bubble
  // (control cleared, data fields are don't-care and simply load), else advance
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_reg     <= 1'b0;
      ex_reg_write_reg <= 1'b0;
      ex_mem_read_reg  <= 1'b0;
      ex_rs1_reg       <= '0;
      ex_rs2_reg       <= '0;
      ex_rd_reg        <= '0;
      ex_rs1_val_reg   <= '0;
      ex_rs2_val_reg   <= '0;
      ex_pc_reg        <= '0;
      ex_imm_reg       <= '0;
    end else begin
      ex_valid_reg     <= bus.id_valid && !kill;
      ex_reg_write_reg <= bus.id_valid && bus.id_reg_write && !kill;
      ex_mem_read_reg  <= bus.id_valid && bus.id_mem_read && !kill;
      ex_rs1_reg       <= bus.id_rs1;
      ex_rs2_reg       <= bus.id_rs2;
      ex_rd_reg        <= bus.id_rd;
      ex_rs1_val_reg   <= src_val[0];
      ex_rs2_val_reg   <= src_val[1];
      ex_pc_reg        <= bus.id_pc;
      ex_imm_reg       <= bus.id_imm;
    end
  end

  // saturating event counters; they stop at all-ones rather than wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_reg <= '0;
      flush_count_reg <= '0;
    end else begin
      if (stall && (stall_count_reg != CNT_MAX)) begin
        stall_count_reg <= stall_count_reg + CNT_ONE;
      end
      if (bus.flush && bus.id_valid && (flush_count_reg != CNT_MAX)) begin
        flush_count_reg <= flush_count_reg + CNT_ONE;
      end
    end
  end

  assign bus.ex_valid     = ex_valid_reg;
  assign bus.ex_reg_write = ex_reg_write_reg;
  assign bus.ex_mem_read  = ex_mem_read_reg;
  assign bus.ex_rs1       = ex_rs1_reg;
  assign bus.ex_rs2       = ex_rs2_reg;
  assign bus.ex_rd        = ex_rd_reg;
  assign bus.ex_rs1_val   = ex_rs1_val_reg;
  assign bus.ex_rs2_val   = ex_rs2_val_reg;
  assign bus.ex_pc        = ex_pc_reg;
  assign bus.ex_imm       = ex_imm_reg;
  assign bus.stall_count  = stall_count_reg;
  assign bus.flush_count  = flush_count_reg;

endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboard bench for id_operand_stage: each cycle the bench computes the
// expected stall and the expected next ID/EX contents from its own model,
// queues them, and compares after the clock edge.
module tb_id_operand_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;
  localparam int SAT_W = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  id_operand_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
  id_operand_stage_if #(.XLEN(XLEN), .CNT_W(SAT_W)) sat_bus ();

  id_operand_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // narrow-counter copy, fed the same stimulus, to reach saturation quickly
  id_operand_stage #(.XLEN(XLEN), .CNT_W(SAT_W)) dut_sat (
    .clk  (clk),
    .reset(reset),
    .bus  (sat_bus.slave)
  );

  assign sat_bus.id_valid     = bus.id_valid;
  assign sat_bus.id_rs1       = bus.id_rs1;
  assign sat_bus.id_rs2       = bus.id_rs2;
  assign sat_bus.id_use_rs1   = bus.id_use_rs1;
  assign sat_bus.id_use_rs2   = bus.id_use_rs2;
  assign sat_bus.id_rd        = bus.id_rd;
  assign sat_bus.id_reg_write = bus.id_reg_write;
  assign sat_bus.id_mem_read  = bus.id_mem_read;
  assign sat_bus.id_pc        = bus.id_pc;
  assign sat_bus.id_imm       = bus.id_imm;
  assign sat_bus.rf_rs1_dout  = bus.rf_rs1_dout;
  assign sat_bus.rf_rs2_dout  = bus.rf_rs2_dout;
  assign sat_bus.wb_reg_write = bus.wb_reg_write;
  assign sat_bus.wb_rd        = bus.wb_rd;
  assign sat_bus.wb_din       = bus.wb_din;
  assign sat_bus.flush        = bus.flush;

  typedef struct {
    logic             chk_data;
    logic             valid;
    logic             reg_write;
    logic             mem_read;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [XLEN-1:0]  rs1_val;
    logic [XLEN-1:0]  rs2_val;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic [CNT_W-1:0] scnt;
    logic [CNT_W-1:0] fcnt;
    logic [SAT_W-1:0] ssat;
  } exp_t;

  exp_t exp_q[$];

  int n_compared = 0;
  int n_mismatch = 0;
  int cyc = 0;

  // bench model of the ID/EX control state and counters
  logic             model_known = 1'b0;
  logic             m_valid, m_mem_read;
  logic [4:0]       m_rd;
  logic [CNT_W-1:0] m_scnt;
  logic [CNT_W-1:0] m_fcnt;
  logic [SAT_W-1:0] m_ssat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatch++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic idle_inputs();
    bus.id_valid     = 1'b0;
    bus.id_rs1       = 5'd0;
    bus.id_rs2       = 5'd0;
    bus.id_use_rs1   = 1'b0;
    bus.id_use_rs2   = 1'b0;
    bus.id_rd        = 5'd0;
    bus.id_reg_write = 1'b0;
    bus.id_mem_read  = 1'b0;
    bus.id_pc        = '0;
    bus.id_imm       = '0;
    bus.rf_rs1_dout  = '0;
    bus.rf_rs2_dout  = '0;
    bus.wb_reg_write = 1'b0;
    bus.wb_rd        = 5'd0;
    bus.wb_din       = '0;
    bus.flush        = 1'b0;
    reset            = 1'b0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic [31:0] pc);
    bus.id_valid     = v;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_use_rs1   = u1;
    bus.id_use_rs2   = u2;
    bus.id_rd        = rd;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.id_pc        = pc;
    bus.id_imm       = pc ^ 32'h0000_0F0F;
  endtask

  function automatic logic [XLEN-1:0] pick(input logic [4:0] idx, input logic [XLEN-1:0] rf);
    if (idx == 5'd0) return '0;
    if (bus.wb_reg_write && bus.wb_rd == idx) return bus.wb_din;
    return rf;
  endfunction

  // one clock: check combinational outputs, predict, clock, compare
  task automatic step();
    exp_t e;
    exp_t g;
    logic hz;
    logic st;
    #1;
    hz = m_valid && m_mem_read && (m_rd != 5'd0) && bus.id_valid &&
         ((bus.id_use_rs1 && bus.id_rs1 == m_rd) || (bus.id_use_rs2 && bus.id_rs2 == m_rd));
    st = hz && !bus.flush;
    if (model_known) begin
      check("stall", {63'd0, bus.stall}, {63'd0, st});
    end
    check("rf_rs1_addr", {59'd0, bus.rf_rs1_addr}, {59'd0, bus.id_rs1});
    check("rf_rs2_addr", {59'd0, bus.rf_rs2_addr}, {59'd0, bus.id_rs2});

    e.chk_data  = 1'b1;
    e.rs1       = bus.id_rs1;
    e.rs2       = bus.id_rs2;
    e.rd        = bus.id_rd;
    e.rs1_val   = pick(bus.id_rs1, bus.rf_rs1_dout);
    e.rs2_val   = pick(bus.id_rs2, bus.rf_rs2_dout);
    e.pc        = bus.id_pc;
    e.imm       = bus.id_imm;
    e.valid     = bus.id_valid;
    e.reg_write = bus.id_valid && bus.id_reg_write;
    e.mem_read  = bus.id_valid && bus.id_mem_read;
    if (reset) begin
      e = '{chk_data: 1'b1, valid: 1'b0, reg_write: 1'b0, mem_read: 1'b0, rs1: '0, rs2: '0,
            rd: '0, rs1_val: '0, rs2_val: '0, pc: '0, imm: '0, scnt: '0, fcnt: '0, ssat: '0};
      m_scnt = '0;
      m_fcnt = '0;
      m_ssat = '0;
      model_known = 1'b1;
    end else begin
      if (st && m_scnt != {CNT_W{1'b1}}) m_scnt = m_scnt + 1;
      if (st && m_ssat != {SAT_W{1'b1}}) m_ssat = m_ssat + 1;
      if (bus.flush && bus.id_valid && m_fcnt != {CNT_W{1'b1}}) m_fcnt = m_fcnt + 1;
      if (bus.flush || hz) begin
        e.chk_data  = 1'b0;
        e.valid     = 1'b0;
        e.reg_write = 1'b0;
        e.mem_read  = 1'b0;
      end
    end
    e.scnt = m_scnt;
    e.fcnt = m_fcnt;
    e.ssat = m_ssat;
    m_valid    = e.valid;
    m_mem_read = e.mem_read;
    m_rd       = e.rd;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    cyc++;
    g = exp_q.pop_front();
    check("ex_valid",     {63'd0, bus.ex_valid},     {63'd0, g.valid});
    check("ex_reg_write", {63'd0, bus.ex_reg_write}, {63'd0, g.reg_write});
    check("ex_mem_read",  {63'd0, bus.ex_mem_read},  {63'd0, g.mem_read});
    check("stall_count",  {32'd0, bus.stall_count},  {32'd0, g.scnt});
    check("flush_count",  {32'd0, bus.flush_count},  {32'd0, g.fcnt});
    check("sat_stall_count", {62'd0, sat_bus.stall_count}, {62'd0, g.ssat});
    if (g.chk_data) begin
      check("ex_rs1",     {59'd0, bus.ex_rs1},     {59'd0, g.rs1});
      check("ex_rs2",     {59'd0, bus.ex_rs2},     {59'd0, g.rs2});
      check("ex_rd",      {59'd0, bus.ex_rd},      {59'd0, g.rd});
      check("ex_rs1_val", {32'd0, bus.ex_rs1_val}, {32'd0, g.rs1_val});
      check("ex_rs2_val", {32'd0, bus.ex_rs2_val}, {32'd0, g.rs2_val});
      check("ex_pc",      {32'd0, bus.ex_pc},      {32'd0, g.pc});
      check("ex_imm",     {32'd0, bus.ex_imm},     {32'd0, g.imm});
    end
    $display("cycle %0d: ex_valid=%0b ex_pc=%h ex_rs1_val=%h stall_count=%0d flush_count=%0d",
             cyc, bus.ex_valid, bus.ex_pc, bus.ex_rs1_val, bus.stall_count, bus.flush_count);
  endtask

  initial begin
    m_valid    = 1'b0;
    m_mem_read = 1'b0;
    m_rd       = '0;
    m_scnt     = '0;
    m_fcnt     = '0;
    m_ssat     = '0;
    idle_inputs();

    // reset with arbitrary inputs
    reset = 1'b1;
    set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 32'h1234_5678);
    bus.flush = 1'b1;
    bus.rf_rs1_dout = 32'hAAAA_5555;
    step();
    step();
    check("reset_stall", {63'd0, bus.stall}, 64'd0);
    idle_inputs();

    // write-back bypass on rs1
    set_id(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 32'h0000_0040);
    bus.rf_rs1_dout  = 32'h11;
    bus.rf_rs2_dout  = 32'h22;
    bus.wb_reg_write = 1'b1;
    bus.wb_rd        = 5'd5;
    bus.wb_din       = 32'hDEAD_BEEF;
    step();
    check("bypass_rs1", {32'd0, bus.ex_rs1_val}, {32'd0, 32'hDEAD_BEEF});
    check("no_bypass_rs2", {32'd0, bus.ex_rs2_val}, 64'h22);
    // x0 never bypasses
    bus.wb_rd  = 5'd0;
    bus.id_rs1 = 5'd0;
    step();
    check("x0_zero", {32'd0, bus.ex_rs1_val}, 64'd0);
    // bypass on rs2, write enable gating
    bus.wb_rd = 5'd6; bus.id_rs1 = 5'd6; bus.id_rs2 = 5'd6; bus.wb_reg_write = 1'b0;
    step();
    bus.wb_reg_write = 1'b1;
    step();
    bus.wb_reg_write = 1'b0;

    // load-use: lw x7 then add using rs2 = x7
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 32'h0000_0100);
    step();
    set_id(1'b1, 5'd2, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 32'h0000_0104);
    #1;
    check("loaduse_stall", {63'd0, bus.stall}, 64'd1);
    step();
    check("bubble_valid", {63'd0, bus.ex_valid}, 64'd0);
    check("loaduse_released", {63'd0, bus.stall}, 64'd0);
    step();
    check("add_in_ex", {32'd0, bus.ex_pc}, 64'h104);
    check("stall_count_one", {32'd0, bus.stall_count}, 64'd1);

    // same sequence without using rs2: no stall
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 32'h0000_0200);
    step();
    set_id(1'b1, 5'd2, 5'd7, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 32'h0000_0204);
    #1;
    check("unused_rs2_no_stall", {63'd0, bus.stall}, 64'd0);
    step();

    // flush versus hazard
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 32'h0000_0300);
    step();
    set_id(1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 32'h0000_0304);
    bus.flush = 1'b1;
    #1;
    check("flush_wins_stall", {63'd0, bus.stall}, 64'd0);
    step();
    bus.flush = 1'b0;
    check("flush_bubble", {63'd0, bus.ex_valid}, 64'd0);
    check("flush_count_one", {32'd0, bus.flush_count}, 64'd1);

    // back-to-back independent addi
    for (int i = 0; i < 4; i++) begin
      set_id(1'b1, 5'(i + 1), 5'd0, 1'b1, 1'b0, 5'(i + 10), 1'b1, 1'b0, 32'h400 + 32'(4 * i));
      step();
      check("b2b_valid", {63'd0, bus.ex_valid}, 64'd1);
      check("b2b_pc", {32'd0, bus.ex_pc}, {32'd0, 32'h400 + 32'(4 * i)});
    end
    check("b2b_no_stall", {32'd0, bus.stall_count}, 64'd1);

    // repeated load-use stalls push the narrow counter into saturation
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 32'h500 + 32'(8 * i));
      step();
      set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 32'h504 + 32'(8 * i));
      step();
      step();
    end
    check("sat_stall_max", {62'd0, sat_bus.stall_count}, 64'd3);
    check("stall_count_four", {32'd0, bus.stall_count}, 64'd4);

    // randomized stream with small register indices, flushes and resets
    for (int i = 0; i < 300; i++) begin
      set_id(1'($urandom_range(0, 9) < 8), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 4), $urandom());
      bus.rf_rs1_dout  = $urandom();
      bus.rf_rs2_dout  = $urandom();
      bus.wb_reg_write = 1'($urandom_range(0, 1));
      bus.wb_rd        = 5'($urandom_range(0, 3));
      bus.wb_din       = $urandom();
      bus.flush        = ($urandom_range(0, 9) == 0);
      reset            = ($urandom_range(0, 49) == 0);
      step();
    end
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
